// File: rtl/weather_sensor_frontend.sv
// Sensor conditioning: debounced snow/rain/cloud flags and a saturated
// moving-average temperature, all presented as registered outputs.
module weather_sensor_frontend #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [1:0] sample_kind,
    input  logic [7:0] sample_data,
    output logic       snow,
    output logic       rain,
    output logic       cloud,
    output logic [6:0] temp,
    output logic       temp_valid,
    output logic       update
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = 8 + AVG_LOG2;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned WARM_W = AVG_LOG2 + 1;
    localparam int unsigned NFLAG  = 3;

    typedef enum logic [1:0] {ST_WARM, ST_RUN, ST_CALC} state_t;

    state_t              state_q, state_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [NFLAG-1:0]    flag_q, flag_d;
    logic [CNT_W-1:0]    cnt_q [NFLAG];
    logic [CNT_W-1:0]    cnt_d [NFLAG];
    logic [7:0]          ring_q [DEPTH];
    logic [AVG_LOG2-1:0] wp_q;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [SUM_W-1:0]    avg_c;
    logic [6:0]          temp_q, temp_d, temp_sat_c;
    logic                ready_q, tv_q, update_q;
    logic                accept_c, temp_acc_c, level_c;

    assign accept_c   = sample_valid & ready_q;
    assign temp_acc_c = accept_c & (sample_kind == 2'd0);
    assign level_c    = |sample_data;

    // Per-flag debounce: count consecutive disagreeing samples of that kind
    always_comb begin
        flag_d = flag_q;
        for (int i = 0; i < NFLAG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept_c && (sample_kind == 2'(i + 1))) begin
                if (level_c == flag_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                    cnt_d[i]  = '0;
                    flag_d[i] = ~flag_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Running sum swaps the oldest ring entry for the new sample
    assign sum_d = sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(sample_data);

    // Average of the ring, clamped to the 7-bit output range
    assign avg_c      = sum_q >> AVG_LOG2;
    assign temp_sat_c = (|avg_c[SUM_W-1:7]) ? 7'h7f : avg_c[6:0];

    // Next-state logic: warm-up until the ring is full, then one CALC per temp
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        temp_d  = temp_q;
        case (state_q)
            ST_WARM: begin
                if (temp_acc_c) begin
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_q == WARM_W'(DEPTH - 1)) state_d = ST_CALC;
                end
            end
            ST_RUN: begin
                if (temp_acc_c) state_d = ST_CALC;
            end
            ST_CALC: begin
                temp_d  = temp_sat_c;
                state_d = ST_RUN;
            end
            default: state_d = ST_WARM;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WARM;
            warm_q   <= '0;
            flag_q   <= '0;
            wp_q     <= '0;
            sum_q    <= '0;
            temp_q   <= '0;
            tv_q     <= 1'b0;
            ready_q  <= 1'b1;
            update_q <= 1'b0;
            for (int i = 0; i < NFLAG; i++) cnt_q[i] <= '0;
            for (int j = 0; j < DEPTH; j++) ring_q[j] <= '0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            flag_q   <= flag_d;
            temp_q   <= temp_d;
            ready_q  <= (state_d != ST_CALC);
            update_q <= (flag_d != flag_q) || (temp_d != temp_q);
            if (state_q == ST_CALC) tv_q <= 1'b1;
            for (int i = 0; i < NFLAG; i++) cnt_q[i] <= cnt_d[i];
            if (temp_acc_c) begin
                ring_q[wp_q] <= sample_data;
                sum_q        <= sum_d;
                wp_q         <= wp_q + AVG_LOG2'(1);
            end
        end
    end

    assign sample_ready = ready_q;
    assign snow         = flag_q[0];
    assign rain         = flag_q[1];
    assign cloud        = flag_q[2];
    assign temp         = temp_q;
    assign temp_valid   = tv_q;
    assign update       = update_q;

endmodule

// File: tb/tb_weather_sensor_frontend.sv
// Bench for weather_sensor_frontend: directed vector table, a reset-in-CALC
// sequence and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_weather_sensor_frontend;

    localparam int N   = 4;
    localparam int DEB = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [1:0] sample_kind = 2'd0;
    logic [7:0] sample_data = 8'd0;
    logic       snow, rain, cloud;
    logic [6:0] temp;
    logic       temp_valid;
    logic       update;

    int checks = 0;
    int errors = 0;

    weather_sensor_frontend #(.DEBOUNCE(DEB), .AVG_LOG2(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_kind  (sample_kind),
        .sample_data  (sample_data),
        .snow         (snow),
        .rain         (rain),
        .cloud        (cloud),
        .temp         (temp),
        .temp_valid   (temp_valid),
        .update       (update)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed vectors: one row per clock, expectations seen after that edge
    typedef struct {
        bit       rst;
        bit       v;
        int       k;
        int       d;
        bit       e_rdy;
        int       e_temp;
        bit       e_tv;
        bit       e_upd;
        int       e_flags;
    } vec_t;
    vec_t vt[$];

    task automatic av(input bit rst, input bit v, input int k, input int d,
                      input bit r, input int t, input bit tv, input bit u, input int fl);
        vec_t x;
        x.rst = rst; x.v = v; x.k = k; x.d = d;
        x.e_rdy = r; x.e_temp = t; x.e_tv = tv; x.e_upd = u; x.e_flags = fl;
        vt.push_back(x);
    endtask

    task automatic rst_row();
        av(1, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Reference model: last N temps in a queue, flags as level + disagree run
    int mq[$];
    int m_run[3];
    bit m_flag[3];
    int m_seen, m_temp;
    bit m_pend, m_ready, m_tv, m_upd;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_flag[i] = 0; end
        m_seen = 0; m_temp = 0; m_pend = 0; m_ready = 1; m_tv = 0; m_upd = 0;
    endtask

    task automatic model_edge(input bit v, input int k, input int d);
        bit acc, chg, npend, lvl;
        int nt, s, f;
        acc = v && m_ready; chg = 0; npend = 0; nt = m_temp;
        if (m_pend) begin
            s = 0;
            foreach (mq[i]) s += mq[i];
            nt = s / N;
            if (nt > 127) nt = 127;
            m_tv = 1;
        end
        if (acc && k != 0) begin
            f = k - 1; lvl = (d != 0);
            if (lvl == m_flag[f]) m_run[f] = 0;
            else begin
                m_run[f]++;
                if (m_run[f] == DEB) begin m_flag[f] = !m_flag[f]; m_run[f] = 0; chg = 1; end
            end
        end
        if (acc && k == 0) begin
            mq.push_back(d);
            if (mq.size() > N) void'(mq.pop_front());
            m_seen++;
            if (m_seen >= N) npend = 1;
        end
        if (nt != m_temp) chg = 1;
        m_temp = nt; m_pend = npend; m_ready = !npend; m_upd = chg;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " ready"},  int'(sample_ready), int'(m_ready));
        check({tag, " temp"},   int'(temp), m_temp);
        check({tag, " tvalid"}, int'(temp_valid), int'(m_tv));
        check({tag, " update"}, int'(update), int'(m_upd));
        check({tag, " snow"},   int'(snow), int'(m_flag[0]));
        check({tag, " rain"},   int'(rain), int'(m_flag[1]));
        check({tag, " cloud"},  int'(cloud), int'(m_flag[2]));
    endtask

    task automatic step(input bit v, input int k, input int d);
        @(negedge clock);
        sample_valid = v; sample_kind = 2'(k); sample_data = 8'(d);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        sample_valid = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // Temps 40,60,80,100 -> one CALC stall, then 70
        rst_row();
        av(0,1,0,40, 1,0,0,0,0); av(0,1,0,60, 1,0,0,0,0); av(0,1,0,80, 1,0,0,0,0);
        av(0,1,0,100, 0,0,0,0,0);
        av(0,0,0,0, 1,70,1,1,0); av(0,0,0,0, 1,70,1,0,0);
        // Saturation, then decay through the ring
        rst_row();
        av(0,1,0,200, 1,0,0,0,0); av(0,1,0,200, 1,0,0,0,0); av(0,1,0,200, 1,0,0,0,0);
        av(0,1,0,200, 0,0,0,0,0); av(0,0,0,0, 1,127,1,1,0);
        av(0,1,0,0, 0,127,1,0,0); av(0,0,0,0, 1,127,1,0,0);
        av(0,1,0,0, 0,127,1,0,0); av(0,0,0,0, 1,100,1,1,0);
        av(0,1,0,0, 0,100,1,0,0); av(0,0,0,0, 1,50,1,1,0);
        av(0,1,0,0, 0,50,1,0,0);  av(0,0,0,0, 1,0,1,1,0);
        // Ring wrap-around
        rst_row();
        av(0,1,0,40, 1,0,0,0,0); av(0,1,0,40, 1,0,0,0,0); av(0,1,0,40, 1,0,0,0,0);
        av(0,1,0,40, 0,0,0,0,0); av(0,0,0,0, 1,40,1,1,0);
        av(0,1,0,120, 0,40,1,0,0); av(0,0,0,0, 1,60,1,1,0);
        av(0,1,0,120, 0,60,1,0,0); av(0,0,0,0, 1,80,1,1,0);
        // Debounce with interleaved rain/temp, then rain and cloud flips
        rst_row();
        av(0,1,1,1, 1,0,0,0,0); av(0,1,1,1, 1,0,0,0,0); av(0,1,1,0, 1,0,0,0,0);
        av(0,1,1,1, 1,0,0,0,0); av(0,1,2,1, 1,0,0,0,0); av(0,1,1,1, 1,0,0,0,0);
        av(0,1,0,5, 1,0,0,0,0); av(0,1,1,1, 1,0,0,1,1); av(0,0,0,0, 1,0,0,0,1);
        av(0,1,2,7, 1,0,0,0,1); av(0,1,2,7, 1,0,0,1,3);
        av(0,1,3,128, 1,0,0,0,3); av(0,1,3,128, 1,0,0,0,3); av(0,1,3,128, 1,0,0,1,7);
        av(0,1,1,0, 1,0,0,0,7); av(0,1,1,0, 1,0,0,0,7); av(0,1,1,0, 1,0,0,1,6);
        // Valid held through CALC: the stalled sample is taken exactly once
        rst_row();
        av(0,1,0,10, 1,0,0,0,0); av(0,1,0,10, 1,0,0,0,0); av(0,1,0,10, 1,0,0,0,0);
        av(0,1,0,10, 0,0,0,0,0);
        av(0,1,0,50, 1,10,1,1,0); av(0,1,0,50, 0,10,1,0,0);
        av(0,0,0,0, 1,20,1,1,0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clock);
            if (vt[i].rst) begin
                sample_valid = 1'b0;
                reset_n = 1'b0;
                #1;
            end else begin
                sample_valid = vt[i].v; sample_kind = 2'(vt[i].k); sample_data = 8'(vt[i].d);
                @(posedge clock);
                #1;
            end
            check($sformatf("vec%0d ready", i),  int'(sample_ready), int'(vt[i].e_rdy));
            check($sformatf("vec%0d temp", i),   int'(temp), vt[i].e_temp);
            check($sformatf("vec%0d tvalid", i), int'(temp_valid), int'(vt[i].e_tv));
            check($sformatf("vec%0d update", i), int'(update), int'(vt[i].e_upd));
            check($sformatf("vec%0d flags", i),  int'({cloud, rain, snow}), vt[i].e_flags);
            if (vt[i].rst) begin #2; reset_n = 1'b1; end
        end

        // Reset while in CALC with a sample offered
        do_reset();
        for (int i = 0; i < N; i++) step(1, 0, 90);
        check("calc ready low", int'(sample_ready), 0);
        @(negedge clock);
        sample_valid = 1'b1; sample_kind = 2'd0; sample_data = 8'd33;
        reset_n = 1'b0;
        #1;
        check("rstcalc ready",  int'(sample_ready), 1);
        check("rstcalc temp",   int'(temp), 0);
        check("rstcalc tvalid", int'(temp_valid), 0);
        check("rstcalc update", int'(update), 0);
        sample_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 90);
            check("post-reset no update", int'(update), 0);
            step(0, 0, 0);
            check("post-reset no tvalid", int'(temp_valid), 0);
            check("post-reset ready", int'(sample_ready), 1);
        end
        step(1, 0, 90);
        step(0, 0, 0);
        check("post-reset 4th temp", int'(temp), 90);
        check("post-reset 4th update", int'(update), 1);

        // Randomized run against the model, with occasional mid-stream resets
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit v;
            int k, d;
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 3);
            if (k == 0) d = $urandom_range(0, 255);
            else d = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255);
            @(negedge clock);
            if ($urandom_range(0, 399) == 0) begin
                sample_valid = v; sample_kind = 2'(k); sample_data = 8'(d);
                reset_n = 1'b0;
                model_reset();
                #1;
                compare_model("rand-reset");
                sample_valid = 1'b0;
                #2;
                reset_n = 1'b1;
            end else begin
                sample_valid = v; sample_kind = 2'(k); sample_data = 8'(d);
                @(posedge clock);
                model_edge(v, k, d);
                #1;
                compare_model("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
